// File: rtl/counter_up_ctl_if.sv
// Control/status bundle for counter_up_ctl: command strobes and operands in,
// registered count and status flags out.
interface counter_up_ctl_if #(
  parameter int dw = 8
);
  logic          ena;
  logic          clr;
  logic          start;
  logic          load;
  logic [dw-1:0] load_val;
  logic          lim_wr;
  logic [dw-1:0] lim_val;
  logic          wrap_mode;
  logic [dw-1:0] result;
  logic          tc;
  logic          done;
  logic          ovf;

  modport master (
    output ena, clr, start, load, load_val, lim_wr, lim_val, wrap_mode,
    input  result, tc, done, ovf
  );

  modport slave (
    input  ena, clr, start, load, load_val, lim_wr, lim_val, wrap_mode,
    output result, tc, done, ovf
  );
endinterface

// File: rtl/counter_up_ctl.sv
// Up-counter with a programmable terminal limit, wrap/stop modes, a one-cycle
// terminal-count pulse, a sticky overflow flag and an IDLE/RUN/HOLD controller.
module counter_up_ctl #(
  parameter int dw    = 8,
  parameter int WIDTH = 7
) (
  input logic           clk,
  input logic           reset,
  counter_up_ctl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [dw-1:0] result, result_n;
  logic [dw-1:0] lim_reg, lim_n;
  logic          tc, tc_n;
  logic          ovf, ovf_n;

  // NOTE: non-blocking assignments make every register sample pre-edge values,
  // so the limit written on an edge is not yet visible to that edge's compare.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      result  <= '0;
      lim_reg <= dw'(WIDTH);
      tc      <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state   <= state_n;
      result  <= result_n;
      lim_reg <= lim_n;
      tc      <= tc_n;
      ovf     <= ovf_n;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_n  = state;
    result_n = result;
    lim_n    = bus.lim_wr ? bus.lim_val : lim_reg;
    tc_n     = 1'b0;
    ovf_n    = ovf;

    if (bus.clr) begin
      state_n  = IDLE;
      result_n = '0;
      ovf_n    = 1'b0;
    end else if (bus.load) begin
      state_n  = RUN;
      result_n = (bus.load_val > lim_reg) ? lim_reg : bus.load_val;
    end else if (bus.start && state != RUN) begin
      // Also recovers the unused encoding back into RUN.
      state_n  = RUN;
      result_n = '0;
    end else if (state == RUN && bus.ena) begin
      if (result >= lim_reg) begin
        // Terminal step; >= also catches a limit lowered below the count.
        tc_n = 1'b1;
        if (bus.wrap_mode) begin
          result_n = '0;
          ovf_n    = 1'b1;
        end else begin
          result_n = lim_reg;
          state_n  = HOLD;
        end
      end else begin
        result_n = result + 1'b1;
      end
    end
  end

  assign bus.result = result;
  assign bus.tc     = tc;
  assign bus.done   = (state == HOLD);
  assign bus.ovf    = ovf;

endmodule
